qnigma_mdio_master: RTL and testbench



---
 rtl/qnigma_mdio_pkg.sv | 42 ++++
 rtl/qnigma_mdio_master_if.sv | 34 +++
 rtl/qnigma_mdio_mdc_gen.sv | 49 ++++
 rtl/qnigma_mdio_master.sv | 181 ++++++++++++++++++
 tb/tb_qnigma_mdio_master.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/qnigma_mdio_pkg.sv
// -----------------------------------------------------------------------------
// qnigma_mdio_pkg
// Shared constants, field widths, FSM state type and frame-assembly helper for
// the Clause 22 MDIO station-management initiator.
// -----------------------------------------------------------------------------
package qnigma_mdio_pkg;

   localparam int PHYAD_W = 5;
   localparam int REGAD_W = 5;
   localparam int DATA_W  = 16;

   // Bits after the preamble: ST(2) OP(2) PHY(5) REG(5) TA(2) DATA(16)
   localparam int FRAME_W = 32;

   localparam logic [1:0] MDIO_ST    = 2'b01;
   localparam logic [1:0] MDIO_OP_RD = 2'b10;
   localparam logic [1:0] MDIO_OP_WR = 2'b01;
   localparam logic [1:0] MDIO_TA_WR = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      PRE,
      HDR,
      TA,
      DAT
   } mdio_mst_state_t;

   // Everything after the preamble as one word, MSB first. For reads the TA and
   // data positions are all ones: the pad is released there and mdo idles high.
   function automatic logic [FRAME_W-1:0] mdio_frame_word(
      input logic               r_nw,
      input logic [PHYAD_W-1:0] phyad,
      input logic [REGAD_W-1:0] regad,
      input logic [DATA_W-1:0]  wdat
   );
      logic [FRAME_W-1:0] w;
      if (r_nw) w = {MDIO_ST, MDIO_OP_RD, phyad, regad, {(2+DATA_W){1'b1}}};
      else      w = {MDIO_ST, MDIO_OP_WR, phyad, regad, MDIO_TA_WR, wdat};
      return w;
   endfunction

endpackage

// File: rtl/qnigma_mdio_master_if.sv
// -----------------------------------------------------------------------------
// qnigma_mdio_master_if
// Host-side request/response bundle of the MDIO initiator.
//   req   : start transaction (honoured only while busy=0)
//   r_nw  : 1 = read, 0 = write
//   phyad : PHY address, regad : register address, wdat : write data
//   busy  : frame in progress, done : one-cycle end-of-frame pulse
//   rdat  : last read data, err : read turnaround error
// Modports: master = host logic issuing requests, slave = the MDIO initiator.
// -----------------------------------------------------------------------------
interface qnigma_mdio_master_if;
   import qnigma_mdio_pkg::*;

   logic               req;
   logic               r_nw;
   logic [PHYAD_W-1:0] phyad;
   logic [REGAD_W-1:0] regad;
   logic [DATA_W-1:0]  wdat;
   logic               busy;
   logic               done;
   logic [DATA_W-1:0]  rdat;
   logic               err;

   modport master (
      output req, r_nw, phyad, regad, wdat,
      input  busy, done, rdat, err
   );

   modport slave (
      input  req, r_nw, phyad, regad, wdat,
      output busy, done, rdat, err
   );

endinterface

// File: rtl/qnigma_mdio_mdc_gen.sv
// -----------------------------------------------------------------------------
// qnigma_mdio_mdc_gen
// MDC generator. While en is high a divider counts 0..MDC_DIV-1; at the
// terminal count mdc toggles. rise/fall flag the cycle in which mdc is about
// to go high/low, so logic registered on that cycle changes together with mdc.
// While en is low the divider and mdc are held at 0.
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   en       : run the divider (frame in progress)
//   mdc      : management clock
//   rise     : strobe, mdc goes 0->1 at the next clk edge
//   fall     : strobe, mdc goes 1->0 at the next clk edge
// -----------------------------------------------------------------------------
module qnigma_mdio_mdc_gen #(
   parameter int MDC_DIV = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic mdc,
   output logic rise,
   output logic fall
);

   localparam int CW = (MDC_DIV > 1) ? $clog2(MDC_DIV) : 1;
   localparam logic [CW-1:0] DIV_LAST = CW'(MDC_DIV - 1);

   logic [CW-1:0] div_q;
   logic          mdc_q;
   logic          tc;

   assign tc   = (div_q == DIV_LAST);
   assign rise = en & tc & ~mdc_q;
   assign fall = en & tc &  mdc_q;
   assign mdc  = mdc_q;

   always_ff @(posedge clk) begin
      if (rst || !en) begin
         div_q <= '0;
         mdc_q <= 1'b0;
      end else if (tc) begin
         div_q <= '0;
         mdc_q <= ~mdc_q;
      end else begin
         div_q <= div_q + 1'b1;
      end
   end

endmodule

// File: rtl/qnigma_mdio_master.sv
// -----------------------------------------------------------------------------
// qnigma_mdio_master
// Clause 22 MDIO station-management initiator. Turns one read/write request
// into a serial frame: PRE_LEN ones, ST, OP, PHYAD, REGAD, TA, 16 data bits.
// mdo/mdt are updated only on MDC fall strobes (and on the first cycle of a
// frame), mdi is sampled only on rise strobes.
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   host     : request/response bundle (req, r_nw, phyad, regad, wdat,
//              busy, done, rdat, err)
//   mdc      : management clock to the pad
//   mdo      : serial data out
//   mdt      : output disable, 1 = pad released
//   mdi      : serial data in
// -----------------------------------------------------------------------------
module qnigma_mdio_master
   import qnigma_mdio_pkg::*;
#(
   parameter int MDC_DIV = 10,
   parameter int PRE_LEN = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   qnigma_mdio_master_if.slave  host,
   output logic                 mdc,
   output logic                 mdo,
   output logic                 mdt,
   input  logic                 mdi
);

   // Last value of the per-state bit counter before leaving each state
   localparam logic [5:0] PRE_LAST = 6'((PRE_LEN > 0) ? PRE_LEN - 1 : 0);
   localparam logic [5:0] HDR_LAST = 6'd13;
   localparam logic [5:0] TA_LAST  = 6'd1;
   localparam logic [5:0] DAT_LAST = 6'd15;

   mdio_mst_state_t    state_q;
   logic [5:0]         cnt_q;
   logic [FRAME_W-1:0] tx_q;
   logic               rd_q;
   logic               busy_q;
   logic               done_q;
   logic               mdo_q;
   logic               mdt_q;
   logic [DATA_W-1:0]  rdat_q;
   logic [DATA_W-1:0]  rdat_sr_q;
   logic               err_q;
   logic               ta_err_q;

   logic               rise;
   logic               fall;
   logic [FRAME_W-1:0] frame_w;

   assign frame_w = mdio_frame_word(host.r_nw, host.phyad, host.regad, host.wdat);

   qnigma_mdio_mdc_gen #(
      .MDC_DIV (MDC_DIV)
   ) u_mdc_gen (
      .clk  (clk),
      .rst  (rst),
      .en   (busy_q),
      .mdc  (mdc),
      .rise (rise),
      .fall (fall)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         rd_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         mdo_q    <= 1'b1;
         mdt_q    <= 1'b1;
         rdat_q   <= '0;
         err_q    <= 1'b0;
         ta_err_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // busy is low in IDLE, so this also covers the done cycle
               if (host.req) begin
                  rd_q     <= host.r_nw;
                  busy_q   <= 1'b1;
                  mdt_q    <= 1'b0;
                  cnt_q    <= '0;
                  ta_err_q <= 1'b0;
                  if (PRE_LEN > 0) begin
                     state_q <= PRE;
                     mdo_q   <= 1'b1;
                     tx_q    <= frame_w;
                  end else begin
                     state_q <= HDR;
                     mdo_q   <= frame_w[FRAME_W-1];
                     tx_q    <= {frame_w[FRAME_W-2:0], 1'b0};
                  end
               end
            end

            PRE: begin
               if (fall) begin
                  if (cnt_q == PRE_LAST) begin
                     state_q <= HDR;
                     cnt_q   <= '0;
                     mdo_q   <= tx_q[FRAME_W-1];
                     tx_q    <= {tx_q[FRAME_W-2:0], 1'b0};
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end

            HDR: begin
               if (fall) begin
                  mdo_q <= tx_q[FRAME_W-1];
                  tx_q  <= {tx_q[FRAME_W-2:0], 1'b0};
                  if (cnt_q == HDR_LAST) begin
                     state_q <= TA;
                     cnt_q   <= '0;
                     // Reads hand the line to the PHY from the first TA bit
                     mdt_q   <= rd_q;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end

            TA: begin
               // A responding PHY pulls the second TA bit low
               if (rise && cnt_q == TA_LAST) ta_err_q <= mdi;
               if (fall) begin
                  mdo_q <= tx_q[FRAME_W-1];
                  tx_q  <= {tx_q[FRAME_W-2:0], 1'b0};
                  if (cnt_q == TA_LAST) begin
                     state_q <= DAT;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end

            DAT: begin
               if (rise) rdat_sr_q <= {rdat_sr_q[DATA_W-2:0], mdi};
               if (fall) begin
                  if (cnt_q == DAT_LAST) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     mdt_q   <= 1'b1;
                     mdo_q   <= 1'b1;
                     cnt_q   <= '0;
                     if (rd_q) begin
                        rdat_q <= rdat_sr_q;
                        err_q  <= ta_err_q;
                     end else begin
                        err_q  <= 1'b0;
                     end
                  end else begin
                     mdo_q <= tx_q[FRAME_W-1];
                     tx_q  <= {tx_q[FRAME_W-2:0], 1'b0};
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end

   assign host.busy = busy_q;
   assign host.done = done_q;
   assign host.rdat = rdat_q;
   assign host.err  = err_q;
   assign mdo       = mdo_q;
   assign mdt       = mdt_q;

endmodule

// File: tb/tb_qnigma_mdio_master.sv
// -----------------------------------------------------------------------------
// tb_qnigma_mdio_master
// Directed bench for the MDIO initiator. dut_a runs MDC_DIV=2/PRE_LEN=32 against
// a serial PHY emulator; dut_b runs MDC_DIV=1/PRE_LEN=0 with a bit monitor.
// Inputs are driven and outputs sampled on the falling clk edge.
// -----------------------------------------------------------------------------
module tb_qnigma_mdio_master;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   qnigma_mdio_master_if ifa ();
   qnigma_mdio_master_if ifb ();

   logic mdc_a, mdo_a, mdt_a;
   logic mdi_a = 1'b1;
   logic mdc_b, mdo_b, mdt_b;
   logic mdi_b = 1'b1;

   qnigma_mdio_master #(.MDC_DIV(2), .PRE_LEN(32)) dut_a (
      .clk (clk), .rst (rst), .host (ifa),
      .mdc (mdc_a), .mdo (mdo_a), .mdt (mdt_a), .mdi (mdi_a)
   );

   qnigma_mdio_master #(.MDC_DIV(1), .PRE_LEN(0)) dut_b (
      .clk (clk), .rst (rst), .host (ifb),
      .mdc (mdc_b), .mdo (mdo_b), .mdt (mdt_b), .mdi (mdi_b)
   );

   int n_chk = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // ---------------- PHY emulator on dut_a ----------------
   logic        phy_on = 1'b1;
   logic [15:0] e_rsp  = 16'h0000;
   wire         pad_a  = mdt_a ? mdi_a : mdo_a;

   logic [2:0]  e_st   = 3'd0;
   logic [4:0]  e_cnt  = 5'd0;
   logic [11:0] e_hdr  = '0;
   logic [15:0] e_dat  = '0;
   logic        e_rd   = 1'b0;
   logic        pmdc_a = 1'b0;
   logic [63:0] cap_a = '0, cap_a_last = '0;
   int          cap_a_n = 0, cap_a_last_n = 0, hiz_a_n = 0, hiz_a_last = 0;
   int          wr_n = 0, done_a_n = 0;
   logic [4:0]  aout = '0;
   logic [15:0] dout = '0;

   always @(negedge clk) begin
      if (rst) begin
         e_st    <= 3'd0;
         e_cnt   <= 5'd0;
         mdi_a   <= 1'b1;
         pmdc_a  <= 1'b0;
         cap_a_n <= 0;
         hiz_a_n <= 0;
      end else begin
         pmdc_a <= mdc_a;
         if (ifa.done) begin
            cap_a_last   <= cap_a;
            cap_a_last_n <= cap_a_n;
            hiz_a_last   <= hiz_a_n;
            done_a_n     <= done_a_n + 1;
         end
         if (!ifa.busy) begin
            cap_a_n <= 0;
            hiz_a_n <= 0;
         end else if (mdc_a && !pmdc_a) begin
            cap_a   <= {cap_a[62:0], pad_a};
            cap_a_n <= cap_a_n + 1;
            if (mdt_a) hiz_a_n <= hiz_a_n + 1;
            case (e_st)
               3'd0: if (!mdt_a && !pad_a) e_st <= 3'd1;
               3'd1: if (pad_a) begin e_st <= 3'd2; e_cnt <= 5'd0; end
               3'd2: begin
                  e_hdr <= {e_hdr[10:0], pad_a};
                  if (e_cnt == 5'd11) begin
                     e_st  <= 3'd3;
                     e_cnt <= 5'd0;
                     e_rd  <= (e_hdr[10:9] == 2'b10);
                  end else e_cnt <= e_cnt + 5'd1;
               end
               3'd3: begin
                  if (e_cnt == 5'd1) begin e_st <= 3'd4; e_cnt <= 5'd0; end
                  else e_cnt <= e_cnt + 5'd1;
               end
               3'd4: begin
                  e_dat <= {e_dat[14:0], pad_a};
                  if (e_cnt == 5'd15) begin
                     e_st  <= 3'd0;
                     e_cnt <= 5'd0;
                     if (!e_rd) begin
                        wr_n <= wr_n + 1;
                        aout <= e_hdr[4:0];
                        dout <= {e_dat[14:0], pad_a};
                     end
                  end else e_cnt <= e_cnt + 5'd1;
               end
               default: e_st <= 3'd0;
            endcase
         end
         // PHY drives on the MDC falling edge so data is settled at the rise
         if (!mdc_a && pmdc_a) begin
            if (e_st == 3'd3 && e_cnt == 5'd1 && e_rd && phy_on) mdi_a <= 1'b0;
            else if (e_st == 3'd4 && e_rd && phy_on)             mdi_a <= e_rsp[~e_cnt[3:0]];
            else                                                 mdi_a <= 1'b1;
         end
      end
   end

   // ---------------- bit monitor on dut_b ----------------
   logic        pmdc_b = 1'b0;
   logic [63:0] cap_b = '0, cap_b_last = '0;
   int          cap_b_n = 0, cap_b_last_n = 0;

   always @(negedge clk) begin
      if (rst) begin
         pmdc_b  <= 1'b0;
         cap_b_n <= 0;
      end else begin
         pmdc_b <= mdc_b;
         if (ifb.done) begin
            cap_b_last   <= cap_b;
            cap_b_last_n <= cap_b_n;
         end
         if (!ifb.busy) cap_b_n <= 0;
         else if (mdc_b && !pmdc_b) begin
            cap_b   <= {cap_b[62:0], mdt_b ? mdi_b : mdo_b};
            cap_b_n <= cap_b_n + 1;
         end
      end
   end

   task automatic wait_done_a(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 4000 && !seen; i++) begin
         @(negedge clk);
         if (ifa.done) seen = 1'b1;
      end
   endtask

   // One transaction on dut_a; returns at the negedge where done is high.
   task automatic run_a(input logic rd, input logic [4:0] pa, input logic [4:0] ra,
                        input logic [15:0] wd, output int lat);
      int t0;
      bit seen;
      @(negedge clk);
      ifa.r_nw = rd; ifa.phyad = pa; ifa.regad = ra; ifa.wdat = wd; ifa.req = 1'b1;
      t0 = cyc;
      @(negedge clk);
      ifa.req = 1'b0;
      chk("start_busy", ifa.busy, 1'b1);
      chk("start_mdc",  mdc_a, 1'b0);
      chk("start_mdo",  mdo_a, 1'b1);
      chk("start_mdt",  mdt_a, 1'b0);
      wait_done_a(seen);
      chk("done_seen", seen, 1'b1);
      lat = cyc - t0;
   endtask

   initial begin
      int lat, w0, d0, t0, d1, d2;
      bit seen;
      ifa.req = 0; ifa.r_nw = 0; ifa.phyad = 0; ifa.regad = 0; ifa.wdat = 0;
      ifb.req = 0; ifb.r_nw = 0; ifb.phyad = 0; ifb.regad = 0; ifb.wdat = 0;

      repeat (3) @(negedge clk);
      chk("rst_busy", ifa.busy, 1'b0);
      chk("rst_done", ifa.done, 1'b0);
      chk("rst_rdat", ifa.rdat, 16'h0000);
      chk("rst_err",  ifa.err,  1'b0);
      chk("rst_mdc",  mdc_a, 1'b0);
      chk("rst_mdo",  mdo_a, 1'b1);
      chk("rst_mdt",  mdt_a, 1'b1);
      chk("rst_b_mdt", mdt_b, 1'b1);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Write phy 1 reg 0x0A data 0xBEEF; 64 bits * 4 clk + 1
      w0 = wr_n;
      run_a(1'b0, 5'd1, 5'h0A, 16'hBEEF, lat);
      chk("wr_lat",  lat, 257);
      chk("wr_busy", ifa.busy, 1'b0);
      chk("wr_mdt",  mdt_a, 1'b1);
      chk("wr_mdo",  mdo_a, 1'b1);
      chk("wr_mdc",  mdc_a, 1'b0);
      chk("wr_err",  ifa.err, 1'b0);
      chk("wr_rdat_hold", ifa.rdat, 16'h0000);
      @(negedge clk);
      chk("wr_done_1cyc", ifa.done, 1'b0);
      chk("wr_bits",  cap_a_last, 64'hFFFF_FFFF_50AA_BEEF);
      chk("wr_nbits", cap_a_last_n, 64);
      chk("wr_hiz",   hiz_a_last, 0);
      chk("emu_vout", wr_n - w0, 1);
      chk("emu_aout", aout, 5'h0A);
      chk("emu_dout", dout, 16'hBEEF);

      // Read phy 1 reg 2, PHY answers 0x0141
      e_rsp = 16'h0141;
      run_a(1'b1, 5'd1, 5'h02, 16'h0000, lat);
      chk("rd_lat",  lat, 257);
      chk("rd_rdat", ifa.rdat, 16'h0141);
      chk("rd_err",  ifa.err, 1'b0);
      chk("rd_mdt",  mdt_a, 1'b1);
      @(negedge clk);
      chk("rd_bits", cap_a_last, 64'hFFFF_FFFF_608A_0141);
      chk("rd_hiz",  hiz_a_last, 18);

      // Read with no PHY: line stays high
      phy_on = 1'b0;
      run_a(1'b1, 5'd1, 5'h02, 16'h0000, lat);
      chk("nophy_err",  ifa.err, 1'b1);
      chk("nophy_rdat", ifa.rdat, 16'hFFFF);
      phy_on = 1'b1;

      // Back-to-back writes with req held high
      @(negedge clk);
      ifa.r_nw = 1'b0; ifa.phyad = 5'd3; ifa.regad = 5'd4; ifa.wdat = 16'h1234; ifa.req = 1'b1;
      w0 = wr_n; d0 = done_a_n; t0 = cyc;
      @(negedge clk);
      ifa.wdat = 16'h5678;
      wait_done_a(seen);
      chk("b2b_seen1", seen, 1'b1);
      d1 = cyc;
      chk("b2b_lat1", d1 - t0, 257);
      chk("b2b_err",  ifa.err, 1'b0);
      chk("b2b_rdat_hold", ifa.rdat, 16'hFFFF);
      @(negedge clk);
      chk("b2b_busy2", ifa.busy, 1'b1);
      chk("b2b_mdc2",  mdc_a, 1'b0);
      chk("b2b_mdo2",  mdo_a, 1'b1);
      chk("b2b_mdt2",  mdt_a, 1'b0);
      repeat (50) @(negedge clk);
      ifa.req = 1'b0;
      wait_done_a(seen);
      chk("b2b_seen2", seen, 1'b1);
      d2 = cyc;
      chk("b2b_lat2", d2 - d1, 257);
      repeat (300) @(negedge clk);
      chk("b2b_pulses", done_a_n - d0, 2);
      chk("b2b_writes", wr_n - w0, 2);
      chk("b2b_dout",   dout, 16'h5678);
      chk("b2b_idle",   ifa.busy, 1'b0);

      // Reset during bit 40 of a read (third clk of the bit, mdc high)
      e_rsp = 16'hA5C3;
      @(negedge clk);
      ifa.r_nw = 1'b1; ifa.phyad = 5'd1; ifa.regad = 5'h02; ifa.req = 1'b1;
      @(negedge clk);
      ifa.req = 1'b0;
      repeat (162) @(negedge clk);
      chk("prerst_mdc", mdc_a, 1'b1);
      chk("prerst_mdt", mdt_a, 1'b0);
      d0 = done_a_n;
      rst = 1'b1;
      @(negedge clk);
      chk("abort_mdc",  mdc_a, 1'b0);
      chk("abort_mdt",  mdt_a, 1'b1);
      chk("abort_mdo",  mdo_a, 1'b1);
      chk("abort_busy", ifa.busy, 1'b0);
      chk("abort_done", ifa.done, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      repeat (400) @(negedge clk);
      chk("abort_no_done", done_a_n - d0, 0);
      run_a(1'b1, 5'd1, 5'h02, 16'h0000, lat);
      chk("post_lat",  lat, 257);
      chk("post_rdat", ifa.rdat, 16'hA5C3);
      chk("post_err",  ifa.err, 1'b0);

      // dut_b: no preamble, MDC = clk/2; 32 bits * 2 clk + 1
      @(negedge clk);
      ifb.r_nw = 1'b0; ifb.phyad = 5'd0; ifb.regad = 5'h1F; ifb.wdat = 16'h0001; ifb.req = 1'b1;
      t0 = cyc;
      @(negedge clk);
      ifb.req = 1'b0;
      chk("b_start_busy", ifb.busy, 1'b1);
      chk("b_start_mdo",  mdo_b, 1'b0);
      chk("b_start_mdt",  mdt_b, 1'b0);
      chk("b_start_mdc",  mdc_b, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 500 && !seen; i++) begin
         @(negedge clk);
         if (ifb.done) seen = 1'b1;
      end
      chk("b_done_seen", seen, 1'b1);
      chk("b_lat", cyc - t0, 65);
      @(negedge clk);
      chk("b_bits",  cap_b_last[31:0], 32'h507E_0001);
      chk("b_nbits", cap_b_last_n, 32);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
